// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronized lock,
// then releases the system reset; retries on lock timeout and parks in FAULT.
module pll_reset_seq #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic       clkin,
    input  logic       resetn,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [3:0] retry_cnt
);

    localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int unsigned MAX_C  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int unsigned CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic          r_sync1;
    logic          r_lock_s;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_retry;
    logic          r_lock_lost;
    logic          r_pll_rst;
    logic          r_sys_rst_n;
    logic          r_ready;
    logic          r_fault;

    logic [2:0]    w_state;
    logic [CW-1:0] w_cnt;
    logic [3:0]    w_retry;
    logic [3:0]    w_retry_inc;
    logic          w_lock_lost;

    // pll_locked is asynchronous to clkin; only r_lock_s feeds decisions
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_locked;
            r_lock_s <= r_sync1;
        end
    end

    assign w_retry_inc = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_retry     = r_retry;
        w_lock_lost = r_lock_lost;
        if (restart) begin
            w_state     = S_RESET_PLL;
            w_cnt       = '0;
            w_retry     = 4'd0;
            w_lock_lost = 1'b0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == RST_LAST) begin
                        w_state = S_WAIT_LOCK;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + CNT_ONE;
                    end
                end
                S_WAIT_LOCK: begin
                    // lock wins over a coincident timeout
                    if (r_lock_s) begin
                        w_state = S_STABLE;
                        w_cnt   = '0;
                    end else if (r_cnt == TO_LAST) begin
                        w_retry = w_retry_inc;
                        w_cnt   = '0;
                        w_state = (w_retry_inc == RETRY_LIM) ? S_FAULT : S_RESET_PLL;
                    end else begin
                        w_cnt = r_cnt + CNT_ONE;
                    end
                end
                S_STABLE: begin
                    if (!r_lock_s) begin
                        w_state = S_WAIT_LOCK;
                        w_cnt   = '0;
                    end else if (r_cnt == STB_LAST) begin
                        w_state = S_RUN;
                        w_cnt   = '0;
                        w_retry = 4'd0;
                    end else begin
                        w_cnt = r_cnt + CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!r_lock_s) begin
                        w_state     = S_RESET_PLL;
                        w_cnt       = '0;
                        w_lock_lost = 1'b1;
                    end
                end
                S_FAULT: begin
                    w_cnt = '0;
                end
                default: begin
                    w_state = S_RESET_PLL;
                    w_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_RESET_PLL;
            r_cnt       <= '0;
            r_retry     <= 4'd0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_retry     <= w_retry;
            r_lock_lost <= w_lock_lost;
        end
    end

    // Outputs decoded from the next state so they change on the transition edge
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_pll_rst   <= (w_state == S_RESET_PLL) || (w_state == S_FAULT);
            r_sys_rst_n <= (w_state == S_RUN);
            r_ready     <= (w_state == S_RUN);
            r_fault     <= (w_state == S_FAULT);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst_n = r_sys_rst_n;
    assign ready     = r_ready;
    assign fault     = r_fault;
    assign lock_lost = r_lock_lost;
    assign retry_cnt = r_retry;

endmodule
